instr_sequencer: RTL and testbench

Multi-cycle control FSM for the 16-bit datapath. It sits directly upstream of the 8x16 register file and operand/ALU stage. It latches one instruction per start handshake, decodes it, and drives readnum/writenum/write plus the operand-load, select and ALU controls in a fixed per-instruction sequence. It asserts w when it is idle and ready for the next instruction.

---
 rtl/instr_sequencer_if.sv | 37 +++
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction handshake and datapath control bundle between the sequencer and
// the register file / ALU stage. The master drives s/instr, the slave drives controls.
interface instr_sequencer_if #(
  parameter int IW = 16,
  parameter int RW = 3
);
  // s is sampled only while w=1; an instruction is accepted on any rising
  // edge where w=1 and s=1, and instr is captured on that same edge.
  logic          s;
  logic [IW-1:0] instr;
  logic          w;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic          vsel;
  logic [IW-1:0] sximm8;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic [1:0]    alu_op;
  logic [1:0]    shift;
  logic          illegal;

  modport master (
    output s, instr,
    input  w, readnum, writenum, write, vsel, sximm8,
           loada, loadb, loadc, loads, asel, alu_op, shift, illegal
  );

  modport slave (
    input  s, instr,
    output w, readnum, writenum, write, vsel, sximm8,
           loada, loadb, loadc, loads, asel, alu_op, shift, illegal
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: latches one instruction per start handshake and
// sequences register-file reads/writes and ALU controls for it.
module instr_sequencer #(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_sequencer_if.slave  bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ir;

  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh;
  logic          is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_legal;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

  assign state_dbg  = state;
  assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && bus.s) ir <= bus.instr;
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.w        = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.alu_op   = 2'b00;
    bus.shift    = 2'b00;
    bus.illegal  = 1'b0;
    case (state)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                state_nxt = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_nxt = S_GET_B;
        else if (is_alu)               state_nxt = S_GET_A;
        else begin
          bus.illegal = 1'b1;
          state_nxt   = S_WAIT;
        end
      end
      S_WRITE_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_nxt   = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_nxt   = S_ALU;
      end
      S_ALU: begin
        bus.shift = sh;
        // CMP only updates flags, so it skips the write-back cycle.
        if (is_cmp) begin
          bus.alu_op = 2'b01;
          bus.loads  = 1'b1;
          state_nxt  = S_WAIT;
        end else if (is_mov_reg) begin
          bus.asel   = 1'b1;
          bus.alu_op = 2'b00;
          bus.loadc  = 1'b1;
          state_nxt  = S_WRITE_REG;
        end else begin
          bus.alu_op = op;
          bus.loadc  = 1'b1;
          state_nxt  = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle expected control vectors are queued when
// an instruction is issued and compared each cycle as the sequencer runs.
module tb_instr_sequencer;

  logic       clk;
  logic       reset_n;
  logic [2:0] state_dbg;
  int         n_checks;
  int         n_pass;

  instr_sequencer_if #(.IW(16), .RW(3)) bus ();

  instr_sequencer #(.IW(16), .RW(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, alu_op, shift, illegal, sximm8}
  logic [34:0] exp_q[$];

  function automatic logic [34:0] vec(
    input logic w, input logic [2:0] rdn, input logic [2:0] wrn, input logic wr,
    input logic vs, input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic [1:0] aop, input logic [1:0] shf, input logic ill,
    input logic [15:0] sx);
    return {w, rdn, wrn, wr, vs, la, lb, lc, ls, as, aop, shf, ill, sx};
  endfunction

  function automatic logic [34:0] sample();
    return {bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel, bus.loada,
            bus.loadb, bus.loadc, bus.loads, bus.asel, bus.alu_op, bus.shift,
            bus.illegal, bus.sximm8};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected cycle-by-cycle controls after the accepting edge, ending with the idle cycle.
  task automatic push_seq(input logic [15:0] ins, output int n, output int lat);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] sx;
    logic        mov_imm, mov_reg, alu, cmp, mvn, legal;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8]; rd = ins[7:5];
    sh = ins[4:3]; rm = ins[2:0];
    sx = {{8{ins[7]}}, ins[7:0]};
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    mvn     = alu && (op == 2'b11);
    legal   = mov_imm || mov_reg || alu;
    n = 0;
    exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, !legal, sx)); n++;
    if (mov_imm) begin
      exp_q.push_back(vec(0, 0, rn, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, sx)); n++;
      lat = 3;
    end else if (legal) begin
      if (alu && !mvn) begin
        exp_q.push_back(vec(0, rn, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, sx)); n++;
      end
      exp_q.push_back(vec(0, rm, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, sx)); n++;
      if (cmp)
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, sh, 0, sx));
      else if (mov_reg)
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, sh, 0, sx));
      else
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, op, sh, 0, sx));
      n++;
      if (!cmp) begin
        exp_q.push_back(vec(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, sx)); n++;
      end
      lat = (mov_reg || mvn || cmp) ? 5 : 6;
    end else begin
      lat = 2;
    end
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, sx)); n++;
  endtask

  // Compare n cycles against the queue; the first cycle with w=1 fixes the latency.
  task automatic compare_cycles(input string tag, input int n, input int lat, inout int cnt, inout bit seen);
    logic [34:0] got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = sample();
      cnt++;
      if (!seen && got[34]) begin
        seen = 1'b1;
        check_val({tag, "_lat"}, 64'(cnt), 64'(lat));
      end
      check_val(tag, 64'(got), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] ins);
    int n, lat, cnt;
    bit seen;
    push_seq(ins, n, lat);
    @(negedge clk);
    bus.s = 1'b1;
    bus.instr = ins;
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    bus.instr = 16'($urandom);
    cnt = 0;
    seen = 1'b0;
    compare_cycles(tag, n, lat, cnt, seen);
    if (!seen) check_val({tag, "_lat"}, 64'(0), 64'(lat));
  endtask

  // s held high across two instructions: the second starts from the first's idle cycle.
  task automatic run_b2b(input logic [15:0] a, input logic [15:0] b);
    int na, nb, la, lb, cnt;
    bit seen;
    push_seq(a, na, la);
    push_seq(b, nb, lb);
    @(negedge clk);
    bus.s = 1'b1;
    bus.instr = a;
    @(posedge clk);
    #1;
    bus.instr = b;
    cnt = 0; seen = 1'b0;
    compare_cycles("b2b_a", na, la, cnt, seen);
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    cnt = 0; seen = 1'b0;
    compare_cycles("b2b_b", nb, lb, cnt, seen);
    if (!seen) check_val("b2b_b_lat", 64'(0), 64'(lb));
  endtask

  logic [34:0] idle_vec;
  logic [15:0] rnd;
  int          na, la;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_vec = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 16'h0000);
    reset_n  = 1'b0;
    bus.s    = 1'b1;
    bus.instr = 16'hD07F;

    // s must not be accepted while reset is held
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("reset_idle", 64'(sample()), 64'(idle_vec));
    end
    bus.s = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_reset", 64'(sample()), 64'(idle_vec));

    run_one("mov_imm7",   16'hD007);
    run_one("mov_imm_m2", 16'hD1FE);
    run_one("add_lsl",    16'hA148);
    run_one("cmp",        16'hA801);
    run_one("mvn",        16'hB860);
    run_one("mov_reg",    16'hC082);
    run_one("illegal",    16'hE000);
    run_one("and_asr",    16'hB3FA);
    run_one("illegal_110_11", 16'hD8FF);
    run_b2b(16'hD37F, 16'hA2B5);

    for (int i = 0; i < 10; i++) begin
      rnd = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0: rnd[15:13] = 3'b110;
        1, 2: rnd[15:13] = 3'b101;
        default: ;
      endcase
      run_one("random", rnd);
    end

    // reset during GET_B of an ADD aborts it with no write-back
    push_seq(16'hA148, na, la);
    @(negedge clk);
    bus.s = 1'b1;
    bus.instr = 16'hA148;
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_pre", 64'(sample()), 64'(exp_q.pop_front()));
    end
    exp_q.delete();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_idle", 64'(sample()), 64'(idle_vec));
    end
    check_val("abort_state", 64'(state_dbg), 64'(0));

    run_one("after_abort", 16'hD2AA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
